// File: rtl/fifo_pkt_framer.sv
// Packet framer behind an FWFT FIFO: a pending word stage decides TLAST before the
// beat is presented, and partial packets close on FLUSH or after an idle timeout.
module fifo_pkt_framer #(
    parameter int WIDTH   = 32,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FIFO_EMPTY,
    input  logic [WIDTH-1:0] FIFO_DATA,
    output logic             FIFO_RD_EN,
    input  logic [LEN_W-1:0] LEN,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] M_TDATA,
    output logic             M_TVALID,
    output logic             M_TLAST,
    input  logic             M_TREADY,
    output logic [15:0]      PKT_CNT
);

    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    logic             p_valid_r;
    logic [WIDTH-1:0] p_data_r;
    logic             p_last_r;
    logic [LEN_W-1:0] wc_r;
    logic [LEN_W-1:0] len_r;
    logic [IDLE_W-1:0] idle_cnt_r;

    logic             out_free_s;
    logic             timeout_hit_s;
    logic             flush_now_s;
    logic             p_move_s;
    logic             pop_s;
    logic [LEN_W-1:0] base_wc_s;
    logic [LEN_W-1:0] len_eff_s;
    logic             new_last_s;
    logic [LEN_W-1:0] wc_next_s;

    // Handshake decisions and word-count bookkeeping for a pop this cycle.
    always_comb begin
        out_free_s    = ~M_TVALID | M_TREADY;
        timeout_hit_s = 1'b0;
        if (TIMEOUT != 0) begin
            timeout_hit_s = (idle_cnt_r >= IDLE_MAX);
        end else begin
            timeout_hit_s = 1'b0;
        end
        flush_now_s = p_valid_r & ~p_last_r & (FLUSH | timeout_hit_s);
        p_move_s    = p_valid_r & out_free_s & (p_last_r | ~FIFO_EMPTY | flush_now_s);
        pop_s       = ~RST & ~FIFO_EMPTY & (~p_valid_r | p_move_s);

        // A word popped alongside a flush move is word 0 of a fresh packet.
        base_wc_s = (p_move_s & flush_now_s) ? {LEN_W{1'b0}} : wc_r;
        if (base_wc_s == {LEN_W{1'b0}}) begin
            len_eff_s = (LEN == {LEN_W{1'b0}}) ? LEN_W'(1) : LEN;
        end else begin
            len_eff_s = len_r;
        end
        new_last_s = (base_wc_s == (len_eff_s - LEN_W'(1)));
        wc_next_s  = new_last_s ? {LEN_W{1'b0}} : (base_wc_s + LEN_W'(1));
    end

    assign FIFO_RD_EN = pop_s;

    // Pending stage, word counter and latched packet length.
    always_ff @(posedge CLK) begin
        if (RST) begin
            p_valid_r <= 1'b0;
            p_data_r  <= {WIDTH{1'b0}};
            p_last_r  <= 1'b0;
            wc_r      <= {LEN_W{1'b0}};
            len_r     <= LEN_W'(1);
        end else if (pop_s) begin
            p_valid_r <= 1'b1;
            p_data_r  <= FIFO_DATA;
            p_last_r  <= new_last_s;
            wc_r      <= wc_next_s;
            len_r     <= len_eff_s;
        end else if (p_move_s) begin
            p_valid_r <= 1'b0;
            p_data_r  <= p_data_r;
            p_last_r  <= 1'b0;
            wc_r      <= flush_now_s ? {LEN_W{1'b0}} : wc_r;
            len_r     <= len_r;
        end else begin
            p_valid_r <= p_valid_r;
            p_data_r  <= p_data_r;
            p_last_r  <= p_last_r;
            wc_r      <= wc_r;
            len_r     <= len_r;
        end
    end

    // Output register: load on a move, drop valid when free and idle, hold when stalled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            M_TDATA  <= {WIDTH{1'b0}};
            M_TVALID <= 1'b0;
            M_TLAST  <= 1'b0;
        end else if (p_move_s) begin
            M_TDATA  <= p_data_r;
            M_TVALID <= 1'b1;
            M_TLAST  <= p_last_r | flush_now_s;
        end else if (out_free_s) begin
            M_TDATA  <= M_TDATA;
            M_TVALID <= 1'b0;
            M_TLAST  <= M_TLAST;
        end else begin
            M_TDATA  <= M_TDATA;
            M_TVALID <= M_TVALID;
            M_TLAST  <= M_TLAST;
        end
    end

    // Completed-packet counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            PKT_CNT <= 16'd0;
        end else if (M_TVALID & M_TREADY & M_TLAST) begin
            PKT_CNT <= PKT_CNT + 16'd1;
        end else begin
            PKT_CNT <= PKT_CNT;
        end
    end

    // Idle counter: runs only while a partial-packet word starves for a successor.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idle_cnt_r <= {IDLE_W{1'b0}};
        end else if (p_valid_r & ~p_last_r & FIFO_EMPTY) begin
            idle_cnt_r <= (idle_cnt_r >= IDLE_MAX) ? idle_cnt_r : (idle_cnt_r + IDLE_W'(1));
        end else begin
            idle_cnt_r <= {IDLE_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Bench for fifo_pkt_framer: bench-side FWFT FIFO, expected-beat queue built from the
// packetisation rules, and directed timing checks around latency, timeout, flush and reset.
module tb_fifo_pkt_framer;
    localparam int WIDTH   = 32;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic             FIFO_EMPTY;
    logic [WIDTH-1:0] FIFO_DATA;
    logic             FIFO_RD_EN;
    logic [LEN_W-1:0] LEN;
    logic             FLUSH;
    logic [WIDTH-1:0] M_TDATA;
    logic             M_TVALID;
    logic             M_TLAST;
    logic             M_TREADY;
    logic [15:0]      PKT_CNT;

    fifo_pkt_framer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
        .FIFO_RD_EN(FIFO_RD_EN), .LEN(LEN), .FLUSH(FLUSH), .M_TDATA(M_TDATA),
        .M_TVALID(M_TVALID), .M_TLAST(M_TLAST), .M_TREADY(M_TREADY), .PKT_CNT(PKT_CNT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int pops = 0;
    int acc = 0;
    int exp_pkts = 0;
    int first_pop_cycle = -1;
    int last_pop_cycle = -1;
    logic [WIDTH-1:0] last_word;
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH:0]   exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic refresh_fifo();
        FIFO_EMPTY = (fifo_q.size() == 0);
        FIFO_DATA  = FIFO_EMPTY ? '0 : fifo_q[0];
    endtask

    // n words, packet length len; close_tail marks the final word as a forced packet end
    task automatic load(input int n, input int len, input bit close_tail);
        logic [WIDTH-1:0] w;
        logic l;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            l = (((i + 1) % len) == 0) || (close_tail && (i == n - 1));
            fifo_q.push_back(w);
            exp_q.push_back({l, w});
            last_word = w;
        end
        refresh_fifo();
    endtask

    task automatic tick();
        logic rd, hs, stalled, in_rst, l;
        logic [WIDTH-1:0] d;
        logic [WIDTH:0] e;
        #1;
        rd = FIFO_RD_EN;
        hs = M_TVALID && M_TREADY;
        stalled = M_TVALID && !M_TREADY;
        in_rst = RST;
        d = M_TDATA;
        l = M_TLAST;
        @(posedge CLK);
        #1;
        cycle++;
        if (rd && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
            last_pop_cycle = cycle - 1;
            if (first_pop_cycle < 0) first_pop_cycle = cycle - 1;
        end
        if (hs && !in_rst) begin
            if (exp_q.size() == 0) begin
                check("beat_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("beat", {31'b0, l, d}, {31'b0, e});
                acc++;
                if (e[WIDTH]) exp_pkts++;
            end
        end
        if (stalled && !in_rst)
            check("stall_hold", {30'b0, M_TVALID, M_TLAST, M_TDATA}, {30'b0, 1'b1, l, d});
        refresh_fifo();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        M_TREADY = 1'b1;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || M_TVALID) && k < 300) begin
            tick();
            k++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()) + 64'(M_TVALID), 64'd0);
    endtask

    initial begin
        int k, p0, a0, lin, len, n;
        bit over;
        RST = 1'b1; FLUSH = 1'b0; M_TREADY = 1'b1; LEN = 8'd4;
        refresh_fifo();
        repeat (3) tick();
        check("rst_tvalid", 64'(M_TVALID), 64'd0);
        check("rst_tlast", 64'(M_TLAST), 64'd0);
        check("rst_tdata", 64'(M_TDATA), 64'd0);
        check("rst_pkt_cnt", 64'(PKT_CNT), 64'd0);
        RST = 1'b0;
        tick();

        // LEN=4, 8 words, sink always ready
        first_pop_cycle = -1;
        load(8, 4, 1'b0);
        k = 0;
        while (!M_TVALID && k < 10) begin tick(); k++; end
        check("t1_latency", 64'(cycle - first_pop_cycle), 64'd2);
        a0 = acc;
        repeat (8) tick();
        check("t1_throughput", 64'(acc - a0), 64'd8);
        drain("t1");
        check("t1_pkt_cnt", 64'(PKT_CNT), 64'd2);

        // LEN=1, every beat is last
        LEN = 8'd1;
        load(3, 1, 1'b0);
        drain("t2");
        check("t2_pkt_cnt", 64'(PKT_CNT), 64'd5);

        // LEN=4, only 2 words: second word closed by the idle timeout
        LEN = 8'd4;
        load(2, 4, 1'b1);
        k = 0;
        while (!(M_TVALID && M_TLAST) && k < 40) begin tick(); k++; end
        check("t3_timeout_lat", 64'(cycle - last_pop_cycle), 64'd18);
        drain("t3a");
        check("t3_pkt_cnt", 64'(PKT_CNT), 64'd6);
        load(4, 4, 1'b0);
        drain("t3b");
        check("t3_next_pkt", 64'(PKT_CNT), 64'd7);

        // LEN=8, 3 words, FLUSH one cycle after the third pop
        LEN = 8'd8;
        p0 = pops;
        load(3, 8, 1'b1);
        k = 0;
        while ((pops - p0) < 3 && k < 10) begin tick(); k++; end
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check("t4_flush_valid", 64'(M_TVALID), 64'd1);
        check("t4_flush_last", 64'(M_TLAST), 64'd1);
        check("t4_flush_data", 64'(M_TDATA), 64'(last_word));
        drain("t4");
        check("t4_pkt_cnt", 64'(PKT_CNT), 64'd8);
        repeat (3) tick();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        repeat (3) tick();
        check("t4_idle_flush_valid", 64'(M_TVALID), 64'd0);
        check("t4_idle_flush_cnt", 64'(PKT_CNT), 64'd8);

        // LEN=4, 8 words, ready pattern 1,0,0,1
        LEN = 8'd4;
        p0 = pops; a0 = acc; over = 1'b0;
        load(8, 4, 1'b0);
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            M_TREADY = ((k % 4) == 0) || ((k % 4) == 3);
            tick();
            if ((pops - p0) - (acc - a0) > 2) over = 1'b1;
            k++;
        end
        drain("t5");
        check("t5_no_overfill", 64'(over), 64'd0);
        check("t5_pkt_cnt", 64'(PKT_CNT), 64'd10);

        // reset after 2 words of a LEN=4 packet
        p0 = pops;
        load(2, 4, 1'b1);
        k = 0;
        while ((pops - p0) < 2 && k < 10) begin tick(); k++; end
        RST = 1'b1;
        exp_q.delete();
        exp_pkts = 0;
        tick();
        check("t6_rst_tvalid", 64'(M_TVALID), 64'd0);
        check("t6_rst_pkt_cnt", 64'(PKT_CNT), 64'd0);
        load(4, 4, 1'b0);
        #1;
        check("t6_rd_in_reset", 64'(FIFO_RD_EN), 64'd0);
        tick();
        check("t6_no_pop_in_reset", 64'(fifo_q.size()), 64'd4);
        RST = 1'b0;
        drain("t6");
        check("t6_pkt_cnt", 64'(PKT_CNT), 64'd1);

        // randomized lengths (including 0) and random sink back-pressure
        for (int it = 0; it < 4; it++) begin
            lin = $urandom_range(0, 5);
            len = (lin == 0) ? 1 : lin;
            n = $urandom_range(3, 14);
            LEN = 8'(lin);
            load(n, len, (n % len) != 0);
            k = 0;
            while (exp_q.size() != 0 && k < 300) begin
                M_TREADY = ($urandom_range(0, 3) != 0);
                tick();
                k++;
            end
            drain("rand");
            check("rand_pkt_cnt", 64'(PKT_CNT), 64'(exp_pkts[15:0]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
